// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Purpose  : Bundles the fetch requester, data requester and memory-side
//             handshake signals of the shared memory port arbiter.
//  Ports    : none (signal container)
//             fetch : i_req, i_addr -> i_ack, i_rdata, i_err
//             data  : d_req, d_we, d_addr, d_size, d_unsigned, d_wdata
//                     -> d_ack, d_rdata, d_err
//             memory: mem_req, mem_we, mem_addr, mem_wdata, mem_be
//                     <- mem_rdata, mem_ready
//             status: busy
//  Modports : slave  - the arbiter itself
//             master - requesters plus memory model driving the arbiter
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
  // fetch requester
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  // data requester
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  // memory side
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  // status
  logic        busy;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_size, d_unsigned, d_wdata,
    input  mem_rdata, mem_ready,
    output i_ack, i_rdata, i_err,
    output d_ack, d_rdata, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output busy
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_size, d_unsigned, d_wdata,
    output mem_rdata, mem_ready,
    input  i_ack, i_rdata, i_err,
    input  d_ack, d_rdata, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-port memory between instruction fetch and
//             load/store data requests. Round-robin on ties, byte-lane
//             steering, byte enables, load extension, alignment check and a
//             ready timeout. Every output is registered.
//  Ports    : clk  - clock
//             rst  - synchronous active-high reset
//             bus  - mem_port_arbiter_if.slave (fetch, data, memory, busy)
//  Params   : TIMEOUT - ACC cycles without mem_ready before abort (1..255)
//             RR_INIT - 0: data counts as last granted, fetch wins first tie
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int TIMEOUT = 15,
  parameter bit RR_INIT = 1'b0
) (
  input  wire logic        clk,
  input  wire logic        rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_ACC     = 2'd1;
  localparam logic [1:0] c_RESP    = 2'd2;
  localparam logic [1:0] c_SZ_WORD = 2'b10;
  localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

  logic [1:0]  r_state;
  logic        r_rr;      // 1: fetch was last granted, 0: data was last granted
  logic [7:0]  r_cnt;
  logic        r_own_d;   // owner of the access in flight: 1 data, 0 fetch
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_we;
  logic        r_uns;

  logic        r_i_ack;
  logic [31:0] r_i_rdata;
  logic        r_i_err;
  logic        r_d_ack;
  logic [31:0] r_d_rdata;
  logic        r_d_err;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic        r_busy;

  logic        w_grant;
  logic        w_grant_d;
  logic [31:0] w_g_addr;
  logic [1:0]  w_g_size;
  logic        w_mis;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [7:0]  w_cnt_nxt;

  // Grant selection and request decode (only meaningful in IDLE).
  // On a tie data wins only if fetch was the last one served.
  always_comb begin
    w_grant   = bus.i_req | bus.d_req;
    w_grant_d = bus.d_req & (~bus.i_req | r_rr);
    w_g_addr  = w_grant_d ? bus.d_addr : bus.i_addr;
    w_g_size  = w_grant_d ? bus.d_size : c_SZ_WORD;
    w_mis     = 1'b0;
    w_be      = 4'hF;
    w_wdata   = bus.d_wdata;
    case (w_g_size)
      2'b00: begin
        w_be    = 4'b0001 << w_g_addr[1:0];
        w_wdata = {4{bus.d_wdata[7:0]}};
      end
      2'b01: begin
        w_mis   = w_g_addr[0];
        w_be    = 4'b0011 << w_g_addr[1:0];
        w_wdata = {2{bus.d_wdata[15:0]}};
      end
      2'b10:   w_mis = |w_g_addr[1:0];
      default: w_mis = 1'b1;
    endcase
    if (!w_grant_d) begin
      w_wdata = '0;
    end
  end

  // Load lane extraction from the returned word using the latched request.
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = bus.mem_rdata[7:0];
      2'd1:    w_byte = bus.mem_rdata[15:8];
      2'd2:    w_byte = bus.mem_rdata[23:16];
      default: w_byte = bus.mem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (r_size)
      2'b00:   w_load = r_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = r_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = bus.mem_rdata;
    endcase
    w_cnt_nxt = r_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_rr        <= RR_INIT;
      r_cnt       <= '0;
      r_own_d     <= 1'b0;
      r_addr      <= '0;
      r_size      <= '0;
      r_we        <= 1'b0;
      r_uns       <= 1'b0;
      r_i_ack     <= 1'b0;
      r_i_rdata   <= '0;
      r_i_err     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_d_rdata   <= '0;
      r_d_err     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_grant) begin
            r_rr    <= ~w_grant_d;
            r_own_d <= w_grant_d;
            r_addr  <= w_g_addr;
            r_size  <= w_g_size;
            r_we    <= w_grant_d & bus.d_we;
            r_uns   <= bus.d_unsigned;
            r_busy  <= 1'b1;
            if (w_mis) begin
              // Misaligned: answer with an error without touching memory.
              r_state   <= c_RESP;
              r_i_ack   <= ~w_grant_d;
              r_i_err   <= ~w_grant_d;
              r_i_rdata <= '0;
              r_d_ack   <= w_grant_d;
              r_d_err   <= w_grant_d;
              r_d_rdata <= '0;
            end else begin
              r_state     <= c_ACC;
              r_mem_req   <= 1'b1;
              r_mem_we    <= w_grant_d & bus.d_we;
              r_mem_addr  <= {w_g_addr[31:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
            end
          end
        end

        c_ACC: begin
          if (bus.mem_ready) begin
            r_state   <= c_RESP;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_i_ack   <= ~r_own_d;
            r_i_err   <= 1'b0;
            r_i_rdata <= r_own_d ? 32'h0 : bus.mem_rdata;
            r_d_ack   <= r_own_d;
            r_d_err   <= 1'b0;
            r_d_rdata <= (r_own_d && !r_we) ? w_load : 32'h0;
          end else begin
            r_cnt <= w_cnt_nxt;
            // Counter holds the number of ACC cycles already spent waiting.
            if (w_cnt_nxt == c_TIMEOUT) begin
              r_state   <= c_RESP;
              r_mem_req <= 1'b0;
              r_mem_we  <= 1'b0;
              r_i_ack   <= ~r_own_d;
              r_i_err   <= ~r_own_d;
              r_i_rdata <= '0;
              r_d_ack   <= r_own_d;
              r_d_err   <= r_own_d;
              r_d_rdata <= '0;
            end
          end
        end

        c_RESP: begin
          r_state   <= c_IDLE;
          r_cnt     <= '0;
          r_busy    <= 1'b0;
          r_i_ack   <= 1'b0;
          r_i_err   <= 1'b0;
          r_i_rdata <= '0;
          r_d_ack   <= 1'b0;
          r_d_err   <= 1'b0;
          r_d_rdata <= '0;
        end

        default: begin
          r_state   <= c_IDLE;
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.i_ack     = r_i_ack;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.i_err     = r_i_err;
  assign bus.d_ack     = r_d_ack;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_err     = r_d_err;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter. A transaction-level
//             model predicts latency, memory strobes and responses; a
//             per-cycle compare process checks the DUT against it, and
//             literal expectations pin the model on the directed vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.TIMEOUT(TO), .RR_INIT(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model: ready on ACC cycle index mem_wait (0-based)
  int          mem_wait = 0;
  logic [31:0] mem_word = 32'h0;
  int          acc_n    = 0;
  assign bus.mem_rdata = mem_word;
  always @(negedge clk) begin
    if (bus.mem_req) begin
      bus.mem_ready = (acc_n == mem_wait);
      acc_n = acc_n + 1;
    end else begin
      bus.mem_ready = 1'b0;
      acc_n = 0;
    end
  end

  // expectation of the access in flight
  bit          chk_en = 1'b0;
  bit          active = 1'b0;
  int          t0 = 0, exp_lat = 0;
  bit          exp_d, exp_mis, exp_we, exp_err;
  logic [31:0] exp_maddr, exp_wdata, exp_rdata;
  logic [3:0]  exp_be;
  bit          m_last_d = 1'b1;  // data counts as last granted after reset

  // observations for literal checks
  logic [31:0] obs_rdata, obs_maddr, obs_wdata;
  logic [3:0]  obs_be;
  bit          obs_err, obs_d;
  int          obs_mreq_n = 0, obs_ack_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] w, input int lo,
                                         input int size, input bit uns);
    longint bits, val;
    bits = 8 << size;
    val  = (longint'(w) >> (8 * lo)) % (longint'(1) << bits);
    if (!uns && val >= (longint'(1) << (bits - 1))) val = val - (longint'(1) << bits);
    return val[31:0];
  endfunction

  function automatic logic [3:0] m_be(input int size, input int lo);
    int n;
    if (size >= 2) return 4'hF;
    n = 1 << size;
    return 4'(((1 << n) - 1) << lo);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input int size);
    if (size == 0) return wd[7:0] * 32'h01010101;
    if (size == 1) return wd[15:0] * 32'h00010001;
    return wd;
  endfunction

  function automatic bit pick();
    if (bus.i_req && bus.d_req) return !m_last_d;
    return bus.d_req;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin : p_cmp
    int diff;
    bit e_ack, e_mreq, e_busy;
    if (chk_en) begin
      diff   = cyc - t0;
      e_ack  = active && diff == exp_lat;
      e_mreq = active && !exp_mis && diff >= 1 && diff < exp_lat;
      e_busy = active && diff >= 1 && diff <= exp_lat;
      chk1("ack_overlap", bus.i_ack & bus.d_ack, 1'b0);
      chk1("i_ack", bus.i_ack, e_ack && !exp_d);
      chk1("d_ack", bus.d_ack, e_ack && exp_d);
      chk1("busy", bus.busy, e_busy);
      chk1("mem_req", bus.mem_req, e_mreq);
      if (bus.mem_req && e_mreq) begin
        chk("mem_addr", bus.mem_addr, exp_maddr);
        chk("mem_be", 32'(bus.mem_be), 32'(exp_be));
        chk1("mem_we", bus.mem_we, exp_we);
        if (exp_we) chk("mem_wdata", bus.mem_wdata, exp_wdata);
      end
      if (e_ack && exp_d) begin
        chk("d_rdata", bus.d_rdata, exp_rdata);
        chk1("d_err", bus.d_err, exp_err);
      end
      if (e_ack && !exp_d) begin
        chk("i_rdata", bus.i_rdata, exp_rdata);
        chk1("i_err", bus.i_err, exp_err);
      end
    end
    if (bus.mem_req) begin
      obs_mreq_n = obs_mreq_n + 1;
      obs_maddr  = bus.mem_addr;
      obs_be     = bus.mem_be;
      obs_wdata  = bus.mem_wdata;
    end
    if (bus.i_ack) begin
      obs_ack_n = obs_ack_n + 1; obs_d = 1'b0; obs_rdata = bus.i_rdata; obs_err = bus.i_err;
    end
    if (bus.d_ack) begin
      obs_ack_n = obs_ack_n + 1; obs_d = 1'b1; obs_rdata = bus.d_rdata; obs_err = bus.d_err;
    end
  end

  // Runs one access for the given owner, whose request is already driven.
  // Called just after a posedge with the DUT in IDLE.
  task automatic run_txn(input bit own_d);
    logic [31:0] ad;
    int lo, size;
    bit got, to;
    if (own_d) begin
      ad = bus.d_addr; size = int'(bus.d_size); exp_we = bus.d_we;
    end else begin
      ad = bus.i_addr; size = 2; exp_we = 1'b0;
    end
    lo        = int'(ad % 4);
    exp_mis   = (size == 3) || ((lo % (1 << size)) != 0);
    to        = !exp_mis && (mem_wait >= TO);
    exp_lat   = exp_mis ? 1 : (to ? 1 + TO : 2 + mem_wait);
    exp_err   = exp_mis || to;
    exp_maddr = ad - 32'(lo);
    exp_be    = own_d ? m_be(size, lo) : 4'hF;
    exp_wdata = own_d ? m_wdata(bus.d_wdata, size) : 32'h0;
    if (exp_err || exp_we) exp_rdata = 32'h0;
    else if (own_d)        exp_rdata = m_load(mem_word, lo, size, bus.d_unsigned);
    else                   exp_rdata = mem_word;
    exp_d      = own_d;
    m_last_d   = own_d;
    t0         = cyc;
    active     = 1'b1;
    obs_mreq_n = 0;
    obs_ack_n  = 0;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #1;
      got = bus.i_ack || bus.d_ack;
    end
    chk1("ack_arrived", got, 1'b1);
    if (own_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
    @(posedge clk); #1;
    active = 1'b0;
  endtask

  task automatic set_d(input bit we, input logic [31:0] a, input logic [1:0] sz,
                       input bit uns, input logic [31:0] wd);
    bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_size = sz;
    bus.d_unsigned = uns; bus.d_wdata = wd;
  endtask

  logic [3:0] ord;
  int         nack;

  initial begin
    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_size = '0;
    bus.d_unsigned = 1'b0; bus.d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_i_ack", bus.i_ack, 1'b0);
    chk1("rst_d_ack", bus.d_ack, 1'b0);
    chk1("rst_mem_req", bus.mem_req, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk("rst_mem_be", 32'(bus.mem_be), 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // simultaneous requests, both re-raised: fetch, data, fetch, data
    mem_word = 32'h00500093; mem_wait = 0;
    for (int r = 0; r < 2; r++) begin
      bus.i_req = 1'b1; bus.i_addr = 32'h100;
      set_d(1'b0, 32'h204, 2'b10, 1'b0, 32'h0);
      run_txn(pick()); ord[2*r]   = obs_d;
      run_txn(pick()); ord[2*r+1] = obs_d;
    end
    chk("grant_order", 32'(ord), 32'hA);

    // plain fetch
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    run_txn(1'b0);
    chk("fetch_rdata", obs_rdata, 32'h00500093);
    chk1("fetch_err", obs_err, 1'b0);
    chk("fetch_be", 32'(obs_be), 32'hF);
    chk("fetch_mreq_cycles", obs_mreq_n, 1);

    // byte loads, signed then unsigned
    mem_word = 32'h80FF1234;
    set_d(1'b0, 32'h203, 2'b00, 1'b0, 32'h0); run_txn(1'b1);
    chk("lb_addr", obs_maddr, 32'h200);
    chk("lb_rdata", obs_rdata, 32'hFFFFFF80);
    set_d(1'b0, 32'h203, 2'b00, 1'b1, 32'h0); run_txn(1'b1);
    chk("lbu_rdata", obs_rdata, 32'h00000080);
    set_d(1'b0, 32'h202, 2'b01, 1'b0, 32'h0); run_txn(1'b1);
    chk("lh_rdata", obs_rdata, 32'hFFFF80FF);
    set_d(1'b0, 32'h200, 2'b01, 1'b1, 32'h0); run_txn(1'b1);
    chk("lhu_rdata", obs_rdata, 32'h00001234);

    // stores
    set_d(1'b1, 32'h302, 2'b01, 1'b0, 32'hABCD1234); run_txn(1'b1);
    chk("sh_be", 32'(obs_be), 32'hC);
    chk("sh_wdata", obs_wdata, 32'h12341234);
    chk("sh_rdata", obs_rdata, 32'h0);
    set_d(1'b1, 32'h301, 2'b00, 1'b0, 32'h0000005A); run_txn(1'b1);
    chk("sb_be", 32'(obs_be), 32'h2);
    chk("sb_wdata", obs_wdata, 32'h5A5A5A5A);

    // misaligned and illegal size
    set_d(1'b0, 32'h102, 2'b10, 1'b0, 32'h0); run_txn(1'b1);
    chk("mis_word_mreq", obs_mreq_n, 0);
    chk1("mis_word_err", obs_err, 1'b1);
    set_d(1'b0, 32'h100, 2'b11, 1'b0, 32'h0); run_txn(1'b1);
    chk1("size11_err", obs_err, 1'b1);
    set_d(1'b1, 32'h101, 2'b01, 1'b0, 32'h0); run_txn(1'b1);
    bus.i_req = 1'b1; bus.i_addr = 32'h102; run_txn(1'b0);
    chk1("mis_fetch_err", obs_err, 1'b1);

    // wait states, up to and past the timeout boundary
    mem_wait = 3;
    bus.i_req = 1'b1; bus.i_addr = 32'h40; run_txn(1'b0);
    mem_wait = TO - 1;
    set_d(1'b0, 32'h80, 2'b10, 1'b0, 32'h0); run_txn(1'b1);
    chk1("late_ready_err", obs_err, 1'b0);
    mem_wait = TO;
    set_d(1'b0, 32'h84, 2'b10, 1'b0, 32'h0); run_txn(1'b1);
    chk1("timeout_err", obs_err, 1'b1);
    chk("timeout_mreq_cycles", obs_mreq_n, TO);
    mem_wait = 1000;
    bus.i_req = 1'b1; bus.i_addr = 32'h88; run_txn(1'b0);
    chk1("timeout_fetch_err", obs_err, 1'b1);

    // reset in the third ACC cycle cancels the access
    chk_en = 1'b0;
    set_d(1'b0, 32'h400, 2'b10, 1'b0, 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    chk1("acc3_mem_req", bus.mem_req, 1'b1);
    chk1("acc3_busy", bus.busy, 1'b1);
    rst = 1'b1; bus.d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_last_d = 1'b1;
    chk1("rstacc_mem_req", bus.mem_req, 1'b0);
    chk1("rstacc_busy", bus.busy, 1'b0);
    nack = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.i_ack || bus.d_ack) nack++;
      @(posedge clk); #1;
    end
    chk("rstacc_no_ack", nack, 0);
    chk_en = 1'b1; active = 1'b0;

    // recovery after reset
    mem_wait = 1; mem_word = 32'h12345678;
    bus.i_req = 1'b1; bus.i_addr = 32'h10; run_txn(1'b0);
    chk("recover_rdata", obs_rdata, 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
